uart_tx_sequencer: RTL and testbench

Controller that drains the shared FIFO (read side: empty/re/dout) and serialises each entry onto a UART TX line: start bit, data LSB-first, optional parity, stop bit(s).
Sits between the TX FIFO and the pad, owns the FIFO read port, and sequences pops so that back-to-back frames go out with zero idle gap.
The CPU fills the FIFO over the bus. This block is the only reader.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/baud_tick_gen.sv | 38 +++
 rtl/uart_tx_sequencer.sv | 153 +++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default framing constants.
// Used by the TX sequencer and intended for reuse by a future RX block.
package uart_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int DEF_XLEN      = 32;
  localparam int DEF_CLK_DIV   = 868;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_PARITY_EN = 0;
  localparam int DEF_STOP_BITS = 1;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: tick marks the last clk cycle of each bit period.
// clear holds the count at zero so the next bit starts a full period.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count 0..CLK_DIV-1, restart on terminal count or clear
  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// Drains the TX FIFO and serialises each word as a UART frame.
// Pops at IDLE or on the last stop cycle so frames run back to back.
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int XLEN      = DEF_XLEN,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int PARITY_EN = DEF_PARITY_EN,
  parameter int STOP_BITS = DEF_STOP_BITS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            fifo_empty,
  input  logic [XLEN-1:0] fifo_dout,
  output logic            fifo_re,
  output logic            tx,
  output logic            busy,
  output logic            frame_done
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_t          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic tick;
  logic baud_clear;
  logic stop_end;
  logic pop;
  logic unused_hi;

  assign unused_hi = ^fifo_dout[XLEN-1:DATA_BITS];

  // Hold the bit timer at zero while idle so START gets a full period
  assign baud_clear = (state_q == ST_IDLE);

  baud_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (baud_clear),
    .tick  (tick)
  );

  // Pop-point detection: idle, or final cycle of the final stop bit
  always_comb begin
    stop_end = (state_q == ST_STOP) && tick && (bit_q == LAST_STOP);
    pop      = reset && enable && !fifo_empty &&
               ((state_q == ST_IDLE) || stop_end);
  end

  // State, shift, counter and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: advance one bit per tick, load a new word on pop
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    unique case (state_q)
      ST_IDLE: begin
        bit_d = '0;
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_DATA) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          bit_d   = '0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_q == LAST_STOP) begin
            state_d = ST_IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        bit_d   = '0;
      end
    endcase
    if (pop) begin
      state_d = ST_START;
      shift_d = fifo_dout[DATA_BITS-1:0];
      par_d   = ^fifo_dout[DATA_BITS-1:0];
      bit_d   = '0;
    end
  end

  // Outputs: line level follows the next state so tx stays registered
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
    busy_d     = (state_d != ST_IDLE);
    fifo_re    = pop;
    frame_done = stop_end;
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench: expected frames queued by stimulus, line monitor
// decodes tx and compares against the queue.
module tb_uart_tx_sequencer;

  localparam int DIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en0, en1, empty0, empty1;
  logic [31:0] dout0, dout1;
  logic        re0, re1, tx0, tx1, busy0, busy1, fd0, fd1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    bit          b2b;
    bit          abort;
  } exp_t;

  exp_t        eq0[$];
  exp_t        eq1[$];
  logic [31:0] f0[$];
  logic [31:0] f1[$];
  logic [31:0] p0[$];
  logic [31:0] p1[$];
  int          pops[2];
  int          coinc[2];
  int          re_viol[2];
  bit          seen0, seen1;

  uart_tx_sequencer #(
    .XLEN(32), .DATA_BITS(8), .CLK_DIV(DIV),
    .PARITY_EN(0), .STOP_BITS(1)
  ) dut0 (
    .clk(clk), .reset(rst_n), .enable(en0),
    .fifo_empty(empty0), .fifo_dout(dout0),
    .fifo_re(re0), .tx(tx0), .busy(busy0),
    .frame_done(fd0)
  );

  uart_tx_sequencer #(
    .XLEN(32), .DATA_BITS(8), .CLK_DIV(DIV),
    .PARITY_EN(1), .STOP_BITS(2)
  ) dut1 (
    .clk(clk), .reset(rst_n), .enable(en1),
    .fifo_empty(empty1), .fifo_dout(dout1),
    .fifo_re(re1), .tx(tx1), .busy(busy1),
    .frame_done(fd1)
  );

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act,
                     input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_frame(input int w, input logic [11:0] bits,
                              input int nbits, input bit b2b,
                              input bit abort);
    exp_t e;
    e.bits  = bits;
    e.nbits = nbits;
    e.b2b   = b2b;
    e.abort = abort;
    if (w == 0) eq0.push_back(e);
    else        eq1.push_back(e);
  endtask

  task automatic push(input int w, input logic [31:0] d);
    if (w == 0) p0.push_back(d);
    else        p1.push_back(d);
  endtask

  task automatic wait_pops(input int w, input int target,
                           input int budget);
    for (int i = 0; i < budget && pops[w] < target; i++) step(1);
    if (pops[w] < target) chk("pop_timeout", pops[w], target);
  endtask

  // FIFO models: pop sampled mid-cycle, applied after the edge
  initial begin
    empty0 = 1'b1;
    dout0  = '0;
    forever begin
      @(negedge clk);
      seen0 = re0;
      if (seen0 && fd0) coinc[0]++;
      if (seen0 && (empty0 || !rst_n)) re_viol[0]++;
      @(posedge clk);
      #1;
      if (seen0) begin
        if (f0.size() > 0) void'(f0.pop_front());
        pops[0]++;
      end
      while (p0.size() > 0) f0.push_back(p0.pop_front());
      empty0 = (f0.size() == 0);
      dout0  = empty0 ? 32'h0 : f0[0];
    end
  end

  initial begin
    empty1 = 1'b1;
    dout1  = '0;
    forever begin
      @(negedge clk);
      seen1 = re1;
      if (seen1 && fd1) coinc[1]++;
      if (seen1 && (empty1 || !rst_n)) re_viol[1]++;
      @(posedge clk);
      #1;
      if (seen1) begin
        if (f1.size() > 0) void'(f1.pop_front());
        pops[1]++;
      end
      while (p1.size() > 0) f1.push_back(p1.pop_front());
      empty1 = (f1.size() == 0);
      dout1  = empty1 ? 32'h0 : f1[0];
    end
  end

  // Line monitor: capture a frame per start bit, compare to queue
  task automatic mon(input int w);
    int last_start = -1000;
    forever begin
      @(negedge clk);
      if (rst_n && ((w == 0) ? tx0 : tx1) == 1'b0) begin
        exp_t        e;
        logic [63:0] act, expv, fda, fde;
        bit          ab, bsy;
        int          n;
        if (((w == 0) ? eq0.size() : eq1.size()) == 0) begin
          chk("unexpected_frame", w, 99);
          repeat (12 * DIV) @(negedge clk);
          continue;
        end
        e = (w == 0) ? eq0.pop_front() : eq1.pop_front();
        n = e.nbits * DIV;
        if (e.b2b) chk("start_gap", cyc - last_start, n);
        last_start = cyc;
        act  = '0;
        expv = '0;
        fda  = '0;
        fde  = 64'd1 << (n - 1);
        ab   = 1'b0;
        bsy  = 1'b1;
        for (int i = 0; i < n; i++) begin
          if (i > 0) @(negedge clk);
          if (!rst_n) begin
            ab = 1'b1;
            break;
          end
          act[i]  = (w == 0) ? tx0 : tx1;
          fda[i]  = (w == 0) ? fd0 : fd1;
          expv[i] = e.bits[i / DIV];
          if (((w == 0) ? busy0 : busy1) == 1'b0) bsy = 1'b0;
        end
        chk("frame_abort", ab, e.abort);
        if (!ab) begin
          chk("frame_bits", act, expv);
          chk("frame_done", fda, fde);
          chk("frame_busy", bsy, 1);
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    rst_n = 1'b0;
    en0   = 1'b0;
    en1   = 1'b0;
    step(3);
    @(negedge clk);
    chk("rst_tx0", tx0, 1);
    chk("rst_busy0", busy0, 0);
    chk("rst_fd0", fd0, 0);
    chk("rst_re0", re0, 0);
    chk("rst_tx1", tx1, 1);
    chk("rst_busy1", busy1, 0);
    step(1);
    rst_n = 1'b1;

    // enable low with data waiting: nothing leaves
    expect_frame(0, 12'b00_1_01010101_0, 10, 0, 0);
    push(0, 32'h55);
    step(20);
    @(negedge clk);
    chk("en_low_pops", pops[0], 0);
    chk("en_low_tx", tx0, 1);
    step(1);
    en0 = 1'b1;
    wait_pops(0, 1, 10);
    step(50);
    @(negedge clk);
    chk("single_pops", pops[0], 1);
    chk("single_busy", busy0, 0);

    // enabled but empty: stays idle
    step(10);
    @(negedge clk);
    chk("empty_busy", busy0, 0);
    chk("empty_pops", pops[0], 1);

    // back to back
    expect_frame(0, 12'b00_1_10100011_0, 10, 0, 0);
    expect_frame(0, 12'b00_1_00001111_0, 10, 1, 0);
    step(1);
    push(0, 32'hA3);
    push(0, 32'h0F);
    wait_pops(0, 3, 60);
    step(50);
    chk("b2b_pops", pops[0], 3);
    chk("b2b_coinc", coinc[0], 1);

    // drop enable during data bit 3
    expect_frame(0, 12'b00_1_00111100_0, 10, 0, 0);
    push(0, 32'h3C);
    push(0, 32'h99);
    wait_pops(0, 4, 10);
    step(18);
    en0 = 1'b0;
    step(60);
    chk("en_drop_pops", pops[0], 4);
    expect_frame(0, 12'b00_1_10011001_0, 10, 0, 0);
    en0 = 1'b1;
    wait_pops(0, 5, 10);
    step(50);
    chk("reen_pops", pops[0], 5);

    // reset during data bit 5
    expect_frame(0, 12'h0, 10, 0, 1);
    expect_frame(0, 12'b00_1_01011010_0, 10, 0, 0);
    push(0, 32'hC6);
    push(0, 32'h5A);
    wait_pops(0, 6, 10);
    step(24);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_tx", tx0, 1);
    chk("midrst_busy", busy0, 0);
    chk("midrst_fd", fd0, 0);
    step(4);
    chk("midrst_pops", pops[0], 6);
    rst_n = 1'b1;
    wait_pops(0, 7, 10);
    step(50);
    chk("post_rst_pops", pops[0], 7);
    chk("re_viol0", re_viol[0], 0);

    // parity + two stop bits, upper word bits ignored
    expect_frame(1, 12'b11_1_00000111_0, 12, 0, 0);
    expect_frame(1, 12'b11_1_00000111_0, 12, 1, 0);
    expect_frame(1, 12'b11_0_10100101_0, 12, 1, 0);
    push(1, 32'h07);
    push(1, 32'hFFFF_FF07);
    push(1, 32'hA5);
    step(2);
    en1 = 1'b1;
    wait_pops(1, 3, 120);
    step(60);
    @(negedge clk);
    chk("par_pops", pops[1], 3);
    chk("par_busy", busy1, 0);
    chk("re_viol1", re_viol[1], 0);

    chk("drain0", eq0.size(), 0);
    chk("drain1", eq1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
